wait_screen_blitter: RTL and testbench
======================================

WAIT_SCREEN_BLITTER -- requirements
Module: wait_screen_blitter

Interface
REQ-001 Parameter X0, default 160, left screen column of the wait-image window.
REQ-002 Parameter Y0, default 130, top screen row of the wait-image window.
REQ-003 Parameter W, default 320, window width in pixels.
REQ-004 Parameter H, default 220, window height in pixels.
REQ-005 Parameter TRANSPARENT, default 9'h1FF, colour key used only when the configuration macro is defined.
REQ-006 Port clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-007 Port reset  input  1  asynchronous, active-high reset.
REQ-008 Port start  input  1  request one full-window copy; sampled in IDLE only.
REQ-009 Port abort  input  1  cancel an in-progress copy.
REQ-010 Port busy  output  1  high in every state except IDLE.
REQ-011 Port done  output  1  one-cycle pulse after the last pixel is accepted.
REQ-012 Port rom_address  output  17  image ROM word address, y_within*W + x_within.
REQ-013 Port rom_data  input  9  ROM colour, valid exactly one cycle after rom_address is presented.
REQ-014 Port fb_x  output  10  framebuffer column of the current pixel.
REQ-015 Port fb_y  output  10  framebuffer row of the current pixel.
REQ-016 Port fb_color  output  9  colour of the current pixel.
REQ-017 Port fb_write  output  1  pixel valid toward the framebuffer writer.
REQ-018 Port fb_ready  input  1  framebuffer writer accepts the pixel.

Function
REQ-019 The FSM SHALL have states IDLE, READ, WAIT, WRITE, DONE.
REQ-020 IDLE->READ when start=1; start in any other state SHALL be ignored.
REQ-021 READ: rom_address = current linear address; READ->WAIT unconditionally after one cycle.
REQ-022 WAIT: rom_data registered into fb_color; WAIT->WRITE unconditionally.
REQ-023 WRITE: fb_write=1 and fb_x/fb_y/fb_color held stable until the cycle where fb_ready=1 (handshake); an accept SHALL be possible in the first WRITE cycle.
REQ-024 On handshake, not last pixel: advance column (wrap x_within W-1->0, increment y_within), increment linear address by 1, go to READ.
REQ-025 On handshake of last pixel (x_within=W-1, y_within=H-1, address W*H-1 = 70399 at defaults): go to DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; counters and address reset to 0.
REQ-027 fb_x = X0 + x_within and fb_y = Y0 + y_within, 10-bit unsigned, no overflow at defaults (max 479, 349).
REQ-028 Linear address SHALL be produced by increment, not multiplication; width 17 bits, never exceeds W*H-1.
REQ-029 abort=1 in any non-IDLE state: next state IDLE, fb_write=0, done not pulsed, counters and address cleared; abort has priority over handshake in the same cycle.
REQ-030 abort in IDLE SHALL have no effect; abort and start together in IDLE: abort wins, remain IDLE.
REQ-031 Minimum throughput SHALL be 3 cycles per pixel when fb_ready is held high.

Reset
REQ-032 Reset asserted SHALL immediately force IDLE, busy=0, done=0, fb_write=0, rom_address=0, fb_x=X0, fb_y=Y0, fb_color=0, counters=0.
REQ-033 Reset mid-copy SHALL discard progress; next start after release begins at pixel (X0,Y0), address 0.

Configuration
REQ-034 Macro WAIT_BLIT_TRANSPARENT_EN SHALL control colour-key skipping.
REQ-035 With WAIT_BLIT_TRANSPARENT_EN defined: in WAIT, if rom_data == TRANSPARENT, the pixel SHALL be skipped (no WRITE, fb_write stays 0) and counters advance as on a handshake; skip of the last pixel goes to DONE.
REQ-036 Without WAIT_BLIT_TRANSPARENT_EN: every pixel, including TRANSPARENT-coloured ones, SHALL be written.

Verification
REQ-037 Reset then start pulse, fb_ready=1, ROM returns address[8:0] -> 70400 writes, first (160,130,color 0), last (479,349,color 70399[8:0]=9'h0FF), done one cycle after last accept, 211200 cycles start-to-done.
REQ-038 fb_ready low for 5 cycles on pixel (200,140) -> fb_write held, fb_x=200, fb_y=140, fb_color stable all 5 cycles, single accept.
REQ-039 Abort asserted during WRITE of pixel 1000 -> busy=0 next cycle, no done; new start -> first write at (160,130), rom_address 0.
REQ-040 start pulses while busy at pixels 10 and 500 -> ignored, exactly 70400 writes, one done.
REQ-041 With WAIT_BLIT_TRANSPARENT_EN, ROM returns 9'h1FF for even addresses -> 35200 writes, all odd addresses, done still pulses; without macro -> 70400 writes.
REQ-042 Reset asserted mid-WAIT -> all outputs at REQ-032 values without waiting for a clock edge.

Source files
------------

// File: rtl/wait_screen_blitter.sv
// Copies a W x H image from ROM into a framebuffer window at (X0,Y0), one pixel per READ/WAIT/WRITE pass.
// Optional colour-key skipping is enabled by defining WAIT_BLIT_TRANSPARENT_EN.
module wait_screen_blitter #(
    parameter int         X0          = 160,
    parameter int         Y0          = 130,
    parameter int         W           = 320,
    parameter int         H           = 220,
    parameter logic [8:0] TRANSPARENT = 9'h1FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [16:0] rom_address,
    input  logic [8:0]  rom_data,
    output logic [9:0]  fb_x,
    output logic [9:0]  fb_y,
    output logic [8:0]  fb_color,
    output logic        fb_write,
    input  logic        fb_ready
);

`ifdef WAIT_BLIT_TRANSPARENT_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t      state, state_nxt;
    logic [9:0]  x_within, y_within;
    logic [16:0] addr;
    logic        last, handshake, skip, step, clear;

    assign last      = (x_within == 10'(W - 1)) && (y_within == 10'(H - 1));
    assign handshake = (state == WRITE) && fb_ready;
    assign skip      = KEY_EN && (state == WAIT) && (rom_data == TRANSPARENT);
    // The last pixel never advances, so the address stays within W*H-1.
    assign step      = (handshake || skip) && !last;
    assign clear     = (abort && state != IDLE) || (state == DONE);

    assign rom_address = addr;
    assign fb_x        = 10'(X0) + x_within;
    assign fb_y        = 10'(Y0) + y_within;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    state_nxt = WAIT;
            WAIT:    state_nxt = skip ? (last ? DONE : READ) : WRITE;
            WRITE:   if (fb_ready) state_nxt = last ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort outranks both start (in IDLE) and a same-cycle handshake.
        if (abort) state_nxt = IDLE;
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE) && !abort;
        fb_write = (state == WRITE) && !abort;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_within <= '0;
            y_within <= '0;
            addr     <= '0;
            fb_color <= '0;
        end else if (clear) begin
            x_within <= '0;
            y_within <= '0;
            addr     <= '0;
        end else begin
            if (state == WAIT) fb_color <= rom_data;
            if (step) begin
                addr <= addr + 17'd1;
                if (x_within == 10'(W - 1)) begin
                    x_within <= '0;
                    y_within <= y_within + 10'd1;
                end else begin
                    x_within <= x_within + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wait_screen_blitter.sv
// Randomized bench for wait_screen_blitter on a small window; expected pixels come from a
// queue built directly from the image table and window geometry.
module tb_wait_screen_blitter;

    localparam int X0 = 160;
    localparam int Y0 = 130;
    localparam int W  = 10;
    localparam int H  = 4;
    localparam int N  = W * H;

`ifdef WAIT_BLIT_TRANSPARENT_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, abort, fb_ready;
    logic        busy, done, fb_write;
    logic [16:0] rom_address;
    logic [8:0]  rom_data, fb_color;
    logic [9:0]  fb_x, fb_y;

    always #5 clk = ~clk;

    wait_screen_blitter #(.X0(X0), .Y0(Y0), .W(W), .H(H), .TRANSPARENT(9'h1FF)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .rom_address(rom_address), .rom_data(rom_data),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write), .fb_ready(fb_ready)
    );

    logic [8:0] rom_tab [N];
    always @(posedge clk) rom_data <= rom_tab[int'(rom_address) % N];

    typedef struct { int x; int y; int c; } pix_t;
    pix_t expq[$];
    pix_t mp;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int n_acc, n_done, done_cyc, last_acc_cyc, n_skip;
    logic       hold_v = 1'b0;
    logic [9:0] hx, hy;
    logic [8:0] hc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void fill(input int mode);
        for (int a = 0; a < N; a++) begin
            case (mode)
                0:       rom_tab[a] = 9'(a);
                1:       rom_tab[a] = (a % 2 == 0) ? 9'h1FF : 9'(a);
                default: rom_tab[a] = ($urandom_range(3) == 0) ? 9'h1FF : 9'($urandom_range(510));
            endcase
        end
    endfunction

    // Expected writes in raster order; keyed pixels drop out only when skipping is built in.
    function automatic void build_exp();
        pix_t p;
        expq.delete();
        n_skip = 0;
        for (int a = 0; a < N; a++) begin
            if (SKIP_EN && rom_tab[a] == 9'h1FF) n_skip++;
            else begin
                p.x = X0 + a % W;
                p.y = Y0 + a / W;
                p.c = int'(rom_tab[a]);
                expq.push_back(p);
            end
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (reset) hold_v = 1'b0;
            else begin
                if (hold_v) begin
                    chk("hold_write", 32'(fb_write), 1);
                    chk("hold_x", 32'(fb_x), 32'(hx));
                    chk("hold_y", 32'(fb_y), 32'(hy));
                    chk("hold_color", 32'(fb_color), 32'(hc));
                end
                if (fb_write && fb_ready) begin
                    if (expq.size() == 0) chk("extra_write", 1, 0);
                    else begin
                        mp = expq.pop_front();
                        chk("pix_x", 32'(fb_x), mp.x);
                        chk("pix_y", 32'(fb_y), mp.y);
                        chk("pix_color", 32'(fb_color), mp.c);
                    end
                    n_acc++;
                    last_acc_cyc = cyc;
                end
                hold_v = fb_write && !fb_ready;
                hx = fb_x; hy = fb_y; hc = fb_color;
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                end
                chk("addr_range", 32'(rom_address < 17'(N)), 1);
            end
        end
    end

    task automatic copy(input int ready_pct, input int hold_at, input int glitch_a,
                        input int glitch_b, input int abort_at, input string tag);
        int t0, budget, hold_cnt;
        bit aborted;
        hold_cnt = 0; budget = 0; aborted = 0;
        build_exp();
        n_acc = 0; n_done = 0;
        @(posedge clk); #1 start = 1'b1; fb_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0; t0 = cyc;
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_addr0"}, 32'(rom_address), 0);
        chk({tag, "_x0"}, 32'(fb_x), X0);
        chk({tag, "_y0"}, 32'(fb_y), Y0);
        while (n_done == 0 && budget < 20 * N) begin
            fb_ready = ($urandom_range(99) < ready_pct);
            if (fb_write && n_acc == hold_at && hold_cnt < 5) begin
                fb_ready = 1'b0;
                hold_cnt++;
            end
            start = busy && (n_acc == glitch_a || n_acc == glitch_b);
            if (abort_at >= 0 && fb_write && n_acc == abort_at) begin
                abort = 1'b1; fb_ready = 1'b1; start = 1'b0;
                @(posedge clk); #1 abort = 1'b0;
                chk({tag, "_abort_busy"}, 32'(busy), 0);
                aborted = 1;
                break;
            end
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        fb_ready = 1'b1;
        if (aborted) begin
            repeat (4) @(posedge clk);
            #1;
            chk({tag, "_abort_nodone"}, 32'(n_done), 0);
            chk({tag, "_abort_acc"}, 32'(n_acc), 32'(abort_at));
            chk({tag, "_abort_idle"}, 32'(busy), 0);
        end else begin
            chk({tag, "_done_seen"}, 32'(n_done), 1);
            repeat (3) @(posedge clk);
            #1;
            chk({tag, "_one_done"}, 32'(n_done), 1);
            chk({tag, "_idle"}, 32'(busy), 0);
            chk({tag, "_writes"}, 32'(n_acc), 32'(N - n_skip));
            chk({tag, "_left"}, 32'(expq.size()), 0);
            if (ready_pct == 100 && hold_at < 0) begin
                chk({tag, "_latency"}, 32'(done_cyc - t0), 32'(3 * (N - n_skip) + 2 * n_skip));
                if (!(SKIP_EN && rom_tab[N-1] == 9'h1FF))
                    chk({tag, "_done_gap"}, 32'(done_cyc - last_acc_cyc), 1);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; fb_ready = 1'b0;
        fill(0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_write", 32'(fb_write), 0);
        chk("rst_addr", 32'(rom_address), 0);
        chk("rst_x", 32'(fb_x), X0);
        chk("rst_y", 32'(fb_y), Y0);
        chk("rst_color", 32'(fb_color), 0);
        reset = 1'b0;

        // abort wins over start while idle
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1 abort = 1'b0; start = 1'b0;
        chk("idle_abort_start", 32'(busy), 0);

        copy(100, -1, -1, -1, -1, "full");
        copy(100, 13, -1, -1, -1, "hold");
        fill(2);
        copy(60, -1, 3, 17, -1, "rand");
        fill(1);
        copy(100, -1, 2, 9, -1, "key");
        fill(0);
        copy(100, -1, -1, -1, 22, "abort");
        copy(100, -1, -1, -1, -1, "after_abort");

        // reset asserted between edges while pixel 7 sits in WAIT
        build_exp();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3 * 7 + 1) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_done", 32'(done), 0);
        chk("async_write", 32'(fb_write), 0);
        chk("async_addr", 32'(rom_address), 0);
        chk("async_x", 32'(fb_x), X0);
        chk("async_y", 32'(fb_y), Y0);
        chk("async_color", 32'(fb_color), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        fill(2);
        copy(80, -1, -1, -1, -1, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
